// File: rtl/hippo_muldiv_pkg.sv
// Shared types and constants for the hippo_muldiv radix-2 multiply/divide unit.
// The HIPPO_MULDIV_EARLY_OUT_EN build option is consumed by hippo_muldiv itself.
package hippo_muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  // Encoded exactly as the RV32M funct3 field.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic a_is_signed(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/hippo_muldiv.sv
// Sequential RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Define HIPPO_MULDIV_EARLY_OUT_EN to finish zero-operand and divide special cases in one cycle.
module hippo_muldiv
  import hippo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output muldiv_state_e    state
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready (IDLE only);
  // a response transfers with resp_valid && resp_ready, and res/resp_valid hold until then.

  muldiv_op_e         op_in;
  muldiv_op_e         op_q;
  logic               neg_mul, neg_q, neg_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   count;

  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               is_div;
  logic [WIDTH:0]     add_x, add_y, add_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, final_res;

  assign op_in     = muldiv_op_e'(op);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign is_div    = op_q[2];

  always_comb begin
    sa    = a_is_signed(op_in) & a[WIDTH-1];
    sb    = b_is_signed(op_in) & b[WIDTH-1];
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;
  end

  // One 33-bit adder serves both: add for multiply, trial subtract for divide.
  always_comb begin
    add_x   = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = {1'b0, mcand};
    add_sum = is_div ? (add_x - add_y) : (add_x + add_y);
    acc_next = acc;
    if (is_div) begin
      if (!add_sum[WIDTH]) acc_next = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                 acc_next = {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {add_sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = neg_mul ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                    final_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:           final_res = quo;
      default:                   final_res = rem;
    endcase
  end

`ifdef HIPPO_MULDIV_EARLY_OUT_EN
  logic             early_hit, sovf;
  logic [WIDTH-1:0] early_res;

  always_comb begin
    sovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    early_hit = (a == '0) || (b == '0) || sovf;
    early_res = '0;
    if (op_in[2]) begin
      if (b == '0)  early_res = op_in[1] ? a : '1;
      else if (sovf) early_res = op_in[1] ? '0 : a;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_MUL;
      neg_mul    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      count      <= '0;
      res        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= op_in;
            neg_mul <= sa ^ sb;
            neg_q   <= (sa ^ sb) && (b != '0);
            neg_r   <= sa;
            acc     <= {{WIDTH{1'b0}}, (op_in[2] ? a_mag : b_mag)};
            mcand   <= op_in[2] ? b_mag : a_mag;
            count   <= '0;
`ifdef HIPPO_MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              state      <= ST_DONE;
              res        <= early_res;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
`else
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CNT_W'(ITER - 1)) begin
            state      <= ST_DONE;
            res        <= final_res;
            resp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hippo_muldiv.sv
// Self-checking bench for hippo_muldiv: directed vector table, random ops against an
// arithmetic reference model, plus backpressure and mid-operation reset sequences.
module tb_hippo_muldiv;
  import hippo_muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  res;
  logic          busy;
  muldiv_state_e state;

  hippo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .op(op), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .res(res), .busy(busy), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int applied = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit/32-bit integer arithmetic with RISC-V special cases.
  function automatic logic [W-1:0] ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int ix, iy;
    logic ovf;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    ix = $signed(x);
    iy = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : W'(ix / iy);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : W'(ix % iy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef HIPPO_MULDIV_EARLY_OUT_EN
    logic sovf;
    sovf = ((o == 3'd4) || (o == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    return ((x == 0) || (y == 0) || sovf) ? 1 : 32;
`else
    return 32 + 0 * int'(o) + 0 * int'(x[0]) + 0 * int'(y[0]);
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output int lat, output bit busy_ok);
    @(negedge clk);
    req_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end while (!resp_valid && lat < 100);
    if (!resp_valid) check("resp_timeout", {31'b0, resp_valid}, 32'd1);
    r = res;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_vector(input string name, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] e);
    logic [W-1:0] r;
    int lat;
    bit busy_ok;
    exp_q.push_back(e);
    run_op(o, x, y, r, lat, busy_ok);
    check({name, "_res"}, r, exp_q.pop_front());
    check({name, "_lat"}, W'(lat), W'(exp_latency(o, x, y)));
    check({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    check({name, "_idle"}, {30'b0, req_ready, resp_valid}, 32'd2);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[14];
    logic [W-1:0] ra, rb;
    logic [2:0] ro;
    bit seen_valid;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
    vecs[13] = '{3'd0, 32'd0,          32'h1234_5678, 32'd0};

    // Reset state
    #12;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) do_vector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Random ops against the reference model, biased toward zero and overflow operands
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rb = '0;
        2, 3: ra = '0;
        4:    begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        5:    rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_vector($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref_model(ro, ra, rb));
    end

    // Backpressure: response held while resp_ready is low, concurrent request ignored
    @(negedge clk);
    req_valid = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 100 && !resp_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid_seen", {31'b0, resp_valid}, 32'd1);
    req_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_res_c%0d", k), res, 32'd14);
      check($sformatf("bp_valid_c%0d", k), {31'b0, resp_valid}, 32'd1);
      check($sformatf("bp_req_ready_c%0d", k), {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    check("bp_hs_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp_after_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_accept", {30'b0, busy, resp_valid}, 32'd0);

    // Reset at cycle 10 of CALC aborts with no response
    @(negedge clk);
    req_valid = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'h0000_6789;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("mid_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen_valid = 1'b1;
    end
    check("abort_no_resp", {31'b0, seen_valid}, 32'd0);
    do_vector("post_reset_mul", 3'd0, 32'd6, 32'd7, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
